life_run_controller: RTL and testbench

Run-control sequencer for the 8x8 (64-cell) life board datapath. Owns the seed source (default or user seed, or a free-running 64-bit LFSR while randomizing). Issues the one-cycle board load strobe and the per-generation advance strobe at a programmable rate. Supports run, pause and single-step, and keeps a generation counter for the display logic.

---
 rtl/life_run_controller.sv | 163 ++++++++++++++++
 tb/tb_life_run_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/life_run_controller.sv
// life_run_controller: run-control sequencer for the 8x8 life board datapath.
// Picks the seed source (user, default or free-running LFSR), strobes the board
// load, paces generation advances in RUN, handles pause/single-step and keeps a
// saturating generation counter.
// Optional build macro AUTO_STOP_EN: pause automatically once the board empties.
module life_run_controller #(
   parameter int unsigned TICK_DIV     = 4,
   parameter int unsigned GEN_W        = 16,
   parameter logic [63:0] SEED_DEFAULT = 64'h0412_6424_0034_3C28
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic             step,
   input  logic             randomize,
   input  logic [63:0]      input_seed,
   input  logic [63:0]      board_q,
   output logic [63:0]      seed_out,
   output logic             load_seed,
   output logic             gen_en,
   output logic [GEN_W-1:0] gen_count,
   output logic [1:0]       state_o,
   output logic             extinct
);

   localparam int unsigned    CNT_W     = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [GEN_W-1:0] GEN_MAX   = {GEN_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LFSR  = 2'd1,
      ST_RUN   = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;

   state_t           state_q;
   logic [63:0]      seed_out_q;
   logic [63:0]      lfsr_q;
   logic             load_q;
   logic             gen_en_q;
   logic [GEN_W-1:0] gen_count_q;
   logic [CNT_W-1:0] tick_q;
   logic             extinct_q;

   logic [63:0]      seed_pick_d;
   logic [63:0]      lfsr_shift_d;
   logic [63:0]      lfsr_d;
   logic [GEN_W-1:0] gen_inc_d;
   logic             auto_stop;

   // Seed selection, next LFSR value with lock-up guard, saturating increment
   always_comb begin
      seed_pick_d  = (input_seed == 64'd0) ? SEED_DEFAULT : input_seed;
      lfsr_shift_d = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
      lfsr_d       = (lfsr_shift_d == 64'd0) ? SEED_DEFAULT : lfsr_shift_d;
      gen_inc_d    = (gen_count_q == GEN_MAX) ? GEN_MAX : gen_count_q + GEN_W'(1);
   end

`ifdef AUTO_STOP_EN
   logic gen_dly_q;

   // Marks the cycle in which the board shows the freshly computed generation
   always_ff @(posedge clk or posedge reset) begin
      if (reset) gen_dly_q <= 1'b0;
      else       gen_dly_q <= gen_en_q;
   end

   assign auto_stop = gen_dly_q && (board_q == 64'd0);
`else
   logic unused_board;
   assign unused_board = ^board_q;
   assign auto_stop    = 1'b0;
`endif

   // Run-control FSM; strobes default low and every output is a register.
   // The tick counter only advances in RUN cycles that stay in RUN, so a pause
   // freezes generation timing exactly where it was.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         seed_out_q  <= SEED_DEFAULT;
         lfsr_q      <= SEED_DEFAULT;
         load_q      <= 1'b0;
         gen_en_q    <= 1'b0;
         gen_count_q <= '0;
         tick_q      <= '0;
         extinct_q   <= 1'b0;
      end else begin
         load_q   <= 1'b0;
         gen_en_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (randomize) begin
                  state_q    <= ST_LFSR;
                  lfsr_q     <= seed_pick_d;
                  seed_out_q <= seed_pick_d;
               end else if (start && !pause) begin
                  state_q     <= ST_RUN;
                  seed_out_q  <= seed_pick_d;
                  load_q      <= 1'b1;
                  tick_q      <= '0;
                  gen_count_q <= '0;
                  extinct_q   <= 1'b0;
               end
            end
            ST_LFSR: begin
               if (randomize) begin
                  lfsr_q     <= lfsr_d;
                  seed_out_q <= lfsr_d;
               end else if (start && !pause) begin
                  state_q     <= ST_RUN;
                  seed_out_q  <= lfsr_q;
                  load_q      <= 1'b1;
                  tick_q      <= '0;
                  gen_count_q <= '0;
                  extinct_q   <= 1'b0;
               end
            end
            ST_RUN: begin
               if (randomize) begin
                  state_q    <= ST_LFSR;
                  lfsr_q     <= seed_pick_d;
                  seed_out_q <= seed_pick_d;
               end else if (pause) begin
                  state_q <= ST_PAUSE;
               end else if (auto_stop) begin
                  state_q   <= ST_PAUSE;
                  extinct_q <= 1'b1;
               end else if (tick_q == TICK_LAST) begin
                  tick_q      <= '0;
                  gen_en_q    <= 1'b1;
                  gen_count_q <= gen_inc_d;
               end else begin
                  tick_q <= tick_q + CNT_W'(1);
               end
            end
            ST_PAUSE: begin
               if (randomize) begin
                  state_q    <= ST_LFSR;
                  lfsr_q     <= seed_pick_d;
                  seed_out_q <= seed_pick_d;
               end else if (start && !pause) begin
                  state_q <= ST_RUN;
               end else if (step) begin
                  gen_en_q    <= 1'b1;
                  gen_count_q <= gen_inc_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign seed_out  = seed_out_q;
   assign load_seed = load_q;
   assign gen_en    = gen_en_q;
   assign gen_count = gen_count_q;
   assign state_o   = state_q;
   assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_run_controller.sv
// Directed, table-driven bench for life_run_controller. A second instance with
// a 2-bit generation counter and a 2-cycle tick exercises counter saturation.
module tb_life_run_controller;

   localparam logic [63:0] DEF = 64'h0412_6424_0034_3C28;
`ifdef AUTO_STOP_EN
   localparam bit AS = 1'b1;
`else
   localparam bit AS = 1'b0;
`endif

   // {start, pause, step, randomize}
   localparam logic [3:0] I_NONE   = 4'b0000;
   localparam logic [3:0] I_START  = 4'b1000;
   localparam logic [3:0] I_PAUSE  = 4'b0100;
   localparam logic [3:0] I_STEP_P = 4'b0110;
   localparam logic [3:0] I_RAND   = 4'b0001;
   localparam logic [3:0] I_ALL    = 4'b1101;

   logic        clk, reset;
   logic        start, pause, step, randomize;
   logic [63:0] input_seed, board_q;

   logic [63:0] seed_out;
   logic        load_seed, gen_en, extinct;
   logic [15:0] gen_count;
   logic [1:0]  state_o;

   logic [63:0] s_seed_out;
   logic        s_load_seed, s_gen_en, s_extinct;
   logic [1:0]  s_gen_count;
   logic [1:0]  s_state_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        start, pause, step, rnd;
      logic [63:0] seed, board;
      logic [1:0]  st;
      logic        ld, ge, ext, sc;
      logic [15:0] cnt;
      logic [63:0] sd;
      int          sat;
   } vec_t;

   vec_t        tbl[$];
   logic [63:0] cur_seed, cur_board;

   life_run_controller dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step),
      .randomize(randomize), .input_seed(input_seed), .board_q(board_q),
      .seed_out(seed_out), .load_seed(load_seed), .gen_en(gen_en),
      .gen_count(gen_count), .state_o(state_o), .extinct(extinct)
   );

   life_run_controller #(.TICK_DIV(2), .GEN_W(2)) dut_sat (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step),
      .randomize(randomize), .input_seed(input_seed), .board_q(board_q),
      .seed_out(s_seed_out), .load_seed(s_load_seed), .gen_en(s_gen_en),
      .gen_count(s_gen_count), .state_o(s_state_o), .extinct(s_extinct)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] in, input logic [1:0] st, input logic ld,
                      input logic ge, input int cnt, input logic ext,
                      input logic sc, input logic [63:0] sd, input int sat);
      vec_t v;
      {v.start, v.pause, v.step, v.rnd} = in;
      v.seed  = cur_seed;
      v.board = cur_board;
      v.st    = st;
      v.ld    = ld;
      v.ge    = ge;
      v.cnt   = 16'(cnt);
      v.ext   = ext;
      v.sc    = sc;
      v.sd    = sd;
      v.sat   = sat;
      tbl.push_back(v);
   endtask

   initial begin
      reset = 1'b1;
      {start, pause, step, randomize} = 4'b0000;
      input_seed = 64'd0;
      board_q    = 64'hFF;
      repeat (2) @(posedge clk);
      #1;
      check("reset state", 64'(state_o), 64'd0);
      check("reset seed_out", seed_out, DEF);
      check("reset load_seed", 64'(load_seed), 64'd0);
      check("reset gen_en", 64'(gen_en), 64'd0);
      check("reset gen_count", 64'(gen_count), 64'd0);
      check("reset extinct", 64'(extinct), 64'd0);
      check("sat reset state", 64'(s_state_o), 64'd0);
      check("sat reset seed_out", s_seed_out, DEF);
      check("sat reset strobes", 64'({s_load_seed, s_gen_en, s_extinct}), 64'd0);
      check("sat reset gen_count", 64'(s_gen_count), 64'd0);
      reset = 1'b0;

      // Load from default seed, generations every 4 cycles; saturation instance alongside
      cur_seed = 64'd0; cur_board = 64'hFF;
      add(I_START, 2, 1, 0, 0, 0, 1, DEF, 0);
      add(I_NONE,  2, 0, 0, 0, 0, 1, DEF, 0);
      add(I_NONE,  2, 0, 0, 0, 0, 0, 0, 1);
      add(I_NONE,  2, 0, 0, 0, 0, 0, 0, 1);
      add(I_NONE,  2, 0, 1, 1, 0, 0, 0, 2);
      add(I_NONE,  2, 0, 0, 1, 0, 0, 0, 2);
      add(I_NONE,  2, 0, 0, 1, 0, 0, 0, 3);
      add(I_NONE,  2, 0, 0, 1, 0, 0, 0, 3);
      add(I_NONE,  2, 0, 1, 2, 0, 0, 0, 3);
      for (int i = 0; i < 3; i++) add(I_NONE, 2, 0, 0, 2, 0, 0, 0, 3);
      add(I_NONE,  2, 0, 1, 3, 0, 0, 0, 3);
      // LFSR from seed 1, then load its current value
      cur_seed = 64'd1;
      add(I_RAND,  1, 0, 0, 3, 0, 1, 64'h1, -1);
      add(I_RAND,  1, 0, 0, 3, 0, 1, 64'h2, -1);
      add(I_RAND,  1, 0, 0, 3, 0, 1, 64'h4, -1);
      add(I_START, 2, 1, 0, 0, 0, 1, 64'h4, -1);
      // Pause at tick 2, two single steps, resume
      add(I_NONE,  2, 0, 0, 0, 0, 0, 0, -1);
      add(I_NONE,  2, 0, 0, 0, 0, 0, 0, -1);
      add(I_PAUSE, 3, 0, 0, 0, 0, 0, 0, -1);
      add(I_PAUSE, 3, 0, 0, 0, 0, 0, 0, -1);
      add(I_STEP_P,3, 0, 1, 1, 0, 0, 0, -1);
      add(I_PAUSE, 3, 0, 0, 1, 0, 0, 0, -1);
      add(I_STEP_P,3, 0, 1, 2, 0, 0, 0, -1);
      add(I_PAUSE, 3, 0, 0, 2, 0, 0, 0, -1);
      add(I_START, 2, 0, 0, 2, 0, 0, 0, -1);
      add(I_NONE,  2, 0, 0, 2, 0, 0, 0, -1);
      add(I_NONE,  2, 0, 1, 3, 0, 0, 0, -1);
      add(I_NONE,  2, 0, 0, 3, 0, 0, 0, -1);
      // Step held high: one generation per cycle
      add(I_PAUSE, 3, 0, 0, 3, 0, 0, 0, -1);
      add(I_STEP_P,3, 0, 1, 4, 0, 0, 0, -1);
      add(I_STEP_P,3, 0, 1, 5, 0, 0, 0, -1);
      add(I_PAUSE, 3, 0, 0, 5, 0, 0, 0, -1);
      // randomize outranks pause and start
      add(I_START, 2, 0, 0, 5, 0, 0, 0, -1);
      add(I_ALL,   1, 0, 0, 5, 0, 1, 64'h1, -1);
      add(I_NONE,  1, 0, 0, 5, 0, 1, 64'h1, -1);
      // Empty board after a generation
      add(I_START, 2, 1, 0, 0, 0, 1, 64'h1, -1);
      for (int i = 0; i < 3; i++) add(I_NONE, 2, 0, 0, 0, 0, 0, 0, -1);
      add(I_NONE,  2, 0, 1, 1, 0, 0, 0, -1);
      cur_board = 64'd0;
      add(I_NONE,  2, 0, 0, 1, 0, 0, 0, -1);
      add(I_NONE,  AS ? 2'd3 : 2'd2, 0, 0, 1, AS, 0, 0, -1);
      add(I_NONE,  AS ? 2'd3 : 2'd2, 0, 0, 1, AS, 0, 0, -1);
      cur_board = 64'hFF;
      add(I_NONE,  AS ? 2'd3 : 2'd2, 0, !AS, AS ? 1 : 2, AS, 0, 0, -1);
      add(I_STEP_P,3, 0, AS, 2, AS, 0, 0, -1);
      add(I_RAND,  1, 0, 0, 2, AS, 1, 64'h1, -1);
      add(I_START, 2, 1, 0, 0, 0, 1, 64'h1, -1);
      // LFSR feedback taps, freeze, continue, load
      cur_seed = 64'h1800_0000_0000_0000;
      add(I_RAND,  1, 0, 0, 0, 0, 1, 64'h1800_0000_0000_0000, -1);
      add(I_RAND,  1, 0, 0, 0, 0, 1, 64'h3000_0000_0000_0000, -1);
      add(I_RAND,  1, 0, 0, 0, 0, 1, 64'h6000_0000_0000_0001, -1);
      add(I_RAND,  1, 0, 0, 0, 0, 1, 64'hC000_0000_0000_0003, -1);
      add(I_RAND,  1, 0, 0, 0, 0, 1, 64'h8000_0000_0000_0006, -1);
      add(I_NONE,  1, 0, 0, 0, 0, 1, 64'h8000_0000_0000_0006, -1);
      add(I_RAND,  1, 0, 0, 0, 0, 1, 64'h0000_0000_0000_000D, -1);
      add(I_NONE,  1, 0, 0, 0, 0, 1, 64'h0000_0000_0000_000D, -1);
      add(I_START, 2, 1, 0, 0, 0, 1, 64'h0000_0000_0000_000D, -1);

      foreach (tbl[i]) begin
         start      = tbl[i].start;
         pause      = tbl[i].pause;
         step       = tbl[i].step;
         randomize  = tbl[i].rnd;
         input_seed = tbl[i].seed;
         board_q    = tbl[i].board;
         @(posedge clk);
         #1;
         check($sformatf("row%0d state_o", i), 64'(state_o), 64'(tbl[i].st));
         check($sformatf("row%0d load_seed", i), 64'(load_seed), 64'(tbl[i].ld));
         check($sformatf("row%0d gen_en", i), 64'(gen_en), 64'(tbl[i].ge));
         check($sformatf("row%0d gen_count", i), 64'(gen_count), 64'(tbl[i].cnt));
         check($sformatf("row%0d extinct", i), 64'(extinct), 64'(tbl[i].ext));
         if (tbl[i].sc)
            check($sformatf("row%0d seed_out", i), seed_out, tbl[i].sd);
         if (tbl[i].sat >= 0)
            check($sformatf("row%0d sat gen_count", i), 64'(s_gen_count), 64'(tbl[i].sat));
      end

      // Reset in the middle of a pending step: everything returns at once
      {start, pause, step, randomize} = I_PAUSE;
      @(posedge clk);
      #1;
      check("pre-reset state", 64'(state_o), 64'd3);
      step = 1'b1;
      #3;
      reset = 1'b1;
      #1;
      check("async reset state", 64'(state_o), 64'd0);
      check("async reset seed_out", seed_out, DEF);
      check("async reset gen_count", 64'(gen_count), 64'd0);
      check("async reset strobes", 64'({load_seed, gen_en, extinct}), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      {start, pause, step, randomize} = I_NONE;
      @(posedge clk);
      #1;
      check("post-reset gen_en", 64'(gen_en), 64'd0);
      check("post-reset state", 64'(state_o), 64'd0);
      check("post-reset gen_count", 64'(gen_count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
